// File: rtl/temp_scan_if.sv
// Signal bundle between temp_scan_ctrl (slave) and the system/sensor side (master).
interface temp_scan_if #(
  parameter int W = 8
);
  logic         enable;
  logic [W-1:0] temp_compare;
  logic         sensAck;
  logic [W-1:0] sensData;
  logic         sensReq;
  logic [1:0]   sensSel;
  logic [W-1:0] avg;
  logic         avgValid;
  logic         tooHot;
  logic         sensFault;
  logic         busy;

  modport master (
    output enable, temp_compare, sensAck, sensData,
    input  sensReq, sensSel, avg, avgValid, tooHot, sensFault, busy
  );

  modport slave (
    input  enable, temp_compare, sensAck, sensData,
    output sensReq, sensSel, avg, avgValid, tooHot, sensFault, busy
  );
endinterface

// File: rtl/temp_scan_ctrl.sv
// Four-sensor scan loop: floor average, debounced over-temperature alarm, sticky timeout fault.
// Optional macro TEMP_HYST_EN: the alarm clears only once avg + HYST <= threshold.
module temp_scan_ctrl #(
  parameter int W       = 8,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 64,
  parameter int HOT_CNT = 3,
  parameter int HYST    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  temp_scan_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int WC_W = $clog2(PERIOD + 1);
  localparam int HC_W = $clog2(HOT_CNT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(PERIOD - 1);
  localparam logic [HC_W-1:0] HOT_MAX   = HC_W'(HOT_CNT);
`ifdef TEMP_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif
  // With the margin at zero the clear test collapses to "not hot".
  localparam logic [W:0] MARGIN = HYST_ON ? (W+1)'(HYST) : '0;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACC, S_CMP, S_WAIT} state_t;

  state_t          r_state, w_next;
  logic [W+1:0]    r_acc;
  logic [W-1:0]    r_data, r_avg;
  logic [1:0]      r_sel;
  logic [TO_W-1:0] r_to_cnt;
  logic [WC_W-1:0] r_wcnt;
  logic [HC_W-1:0] r_hot_cnt;
  logic            r_req, r_busy, r_avg_vld, r_too_hot, r_fault;

  logic [W-1:0]    w_avg_new;
  logic [HC_W-1:0] w_hot_inc;
  logic            w_hot, w_clear, w_to_hit, w_wait_done;

  assign w_avg_new   = r_acc[W+1:2];
  assign w_hot       = w_avg_new > bus.temp_compare;
  assign w_clear     = ({1'b0, w_avg_new} + MARGIN) <= {1'b0, bus.temp_compare};
  assign w_hot_inc   = (r_hot_cnt == HOT_MAX) ? HOT_MAX : r_hot_cnt + HC_W'(1);
  assign w_to_hit    = (r_to_cnt == TO_LAST);
  assign w_wait_done = (r_wcnt >= WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!bus.enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_REQ;
        S_REQ: begin
          if (bus.sensAck)   w_next = S_ACC;
          else if (w_to_hit) w_next = S_WAIT;
        end
        S_ACC:  w_next = (r_sel == 2'd3) ? S_CMP : S_REQ;
        S_CMP:  w_next = S_WAIT;
        S_WAIT: if (w_wait_done) w_next = S_REQ;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_data    <= '0;
      r_avg     <= '0;
      r_sel     <= '0;
      r_to_cnt  <= '0;
      r_wcnt    <= '0;
      r_hot_cnt <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_avg_vld <= 1'b0;
      r_too_hot <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_req     <= (w_next == S_REQ);
      r_busy    <= (w_next == S_REQ) || (w_next == S_ACC) || (w_next == S_CMP);
      r_avg_vld <= 1'b0;
      if (!bus.enable) begin
        r_sel    <= '0;
        r_acc    <= '0;
        r_to_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sel    <= '0;
            r_acc    <= '0;
            r_to_cnt <= '0;
          end
          S_REQ: begin
            if (bus.sensAck) begin
              r_data   <= bus.sensData;
              r_to_cnt <= '0;
            end else if (w_to_hit) begin
              r_fault  <= 1'b1;
              r_acc    <= '0;
              r_sel    <= '0;
              r_to_cnt <= '0;
              r_wcnt   <= WC_W'(1);
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          S_ACC: begin
            r_acc <= r_acc + {2'b00, r_data};
            if (r_sel != 2'd3) r_sel <= r_sel + 2'd1;
          end
          S_CMP: begin
            r_avg     <= w_avg_new;
            r_avg_vld <= 1'b1;
            r_fault   <= 1'b0;
            r_sel     <= '0;
            r_wcnt    <= WC_W'(1);
            if (w_hot) begin
              r_hot_cnt <= w_hot_inc;
              if (w_hot_inc == HOT_MAX) r_too_hot <= 1'b1;
            end else begin
              r_hot_cnt <= '0;
              if (w_clear) r_too_hot <= 1'b0;
            end
          end
          S_WAIT: begin
            if (w_wait_done) begin
              r_acc    <= '0;
              r_sel    <= '0;
              r_to_cnt <= '0;
            end else begin
              r_wcnt <= r_wcnt + WC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sensReq   = r_req;
  assign bus.sensSel   = r_sel;
  assign bus.avg       = r_avg;
  assign bus.avgValid  = r_avg_vld;
  assign bus.tooHot    = r_too_hot;
  assign bus.sensFault = r_fault;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Scoreboard bench for temp_scan_ctrl: expected averages queued per scan, popped on avgValid.
module tb_temp_scan_ctrl;
  localparam int W       = 8;
  localparam int PERIOD  = 12;
  localparam int TIMEOUT = 64;
  localparam int HOT_CNT = 3;
  localparam int HYST    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_q[$];
  int   rd[4];
  int   noack_sel = 4;
  int   last_avg = 0;

  temp_scan_if #(.W(W)) bus ();

  temp_scan_ctrl #(
    .W(W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .HOT_CNT(HOT_CNT), .HYST(HYST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: acks in the first REQ cycle unless the selected sensor is the dead one
  initial begin
    bus.sensAck  = 1'b0;
    bus.sensData = '0;
    forever begin
      @(negedge clk);
      if (bus.sensReq && int'(bus.sensSel) != noack_sel) begin
        bus.sensAck  = 1'b1;
        bus.sensData = W'(rd[bus.sensSel]);
      end else begin
        bus.sensAck  = 1'b0;
        bus.sensData = '0;
      end
    end
  end

  // Scoreboard: every avgValid pulse must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.avgValid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: avgValid with avg=%0d, required no update", bus.avg);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (bus.avg !== W'(e)) begin
            errors++;
            $display("FAIL sb_avg: got %0d, want %0d", bus.avg, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.avgValid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req_sel(input int sel, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.sensReq && int'(bus.sensSel) == sel) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [W+6:0] outs;
    tick(2);
    outs = {bus.sensReq, bus.sensSel, bus.avg, bus.avgValid, bus.tooHot, bus.sensFault, bus.busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h, want 0", outs); end
    rst_n = 1'b1;
    bus.temp_compare = 8'd200;
    rd = '{4, 4, 4, 4};
    noack_sel = 2;
    bus.enable = 1'b1;
    wait_req_sel(2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_reach_sel2: got timeout, want REQ on sensor 2"); end
    rst_n = 1'b0;
    #1;
    outs = {bus.sensReq, bus.sensSel, bus.avg, bus.avgValid, bus.tooHot, bus.sensFault, bus.busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async: got %h, want 0", outs); end
    @(negedge clk);
    outs = {bus.sensReq, bus.sensSel, bus.avg, bus.avgValid, bus.tooHot, bus.sensFault, bus.busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_hold: got %h, want 0", outs); end
    noack_sel = 4;
    exp_q.push_back(4);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sensReq) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || bus.sensSel !== 2'd0) begin
      errors++; $display("FAIL reset_restart_sel: got req=%0d sel=%0d, want req=1 sel=0", ok, bus.sensSel);
    end
    wait_valid(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_scan_done: got timeout, want avgValid"); end
    last_avg = 4;
    bus.enable = 1'b0;
    tick(3);
  endtask

  task automatic test_basic_avg();
    bit ok;
    int t_req, t_vld;
    rd = '{10, 20, 30, 41};
    bus.temp_compare = 8'd200;
    exp_q.push_back(25);
    exp_q.push_back(25);
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sensReq !== 1'b1 || bus.sensSel !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: got req=%0d sel=%0d busy=%0d, want 1 0 1", bus.sensReq, bus.sensSel, bus.busy);
    end
    t_req = cyc;
    wait_valid(40, ok);
    t_vld = cyc;
    checks++;
    if (!ok || (t_vld - t_req) != 9) begin
      errors++; $display("FAIL basic_latency: got %0d, want 9", t_vld - t_req);
    end
    @(negedge clk);
    checks++;
    if (bus.avgValid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got avgValid=1, want 0"); end
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (bus.sensReq) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || (cyc - (t_vld - 1)) != PERIOD) begin
      errors++; $display("FAIL basic_period: got %0d, want %0d", cyc - (t_vld - 1), PERIOD);
    end
    wait_valid(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_second: got timeout, want avgValid"); end
    last_avg = 25;
    bus.enable = 1'b0;
    tick(3);
  endtask

  task automatic test_hot_debounce();
    bit ok;
    int v[8];
    bit h[8];
    v = '{60, 60, 60, 40, 60, 60, 40, 60};
    h = '{0, 0, 1, 0, 0, 0, 0, 0};
    bus.temp_compare = 8'd50;
    rd = '{v[0], v[0], v[0], v[0]};
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(v[i]);
      wait_valid(PERIOD + 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hot_scan%0d: got timeout, want avgValid", i); end
      checks++;
      if (bus.tooHot !== h[i]) begin
        errors++; $display("FAIL hot_flag%0d: got %0d, want %0d", i, bus.tooHot, h[i]);
      end
      if (i < 7) rd = '{v[i+1], v[i+1], v[i+1], v[i+1]};
    end
    last_avg = v[7];
    bus.enable = 1'b0;
    tick(3);
  endtask

  task automatic test_hysteresis();
    bit ok;
    int n;
    int v[6];
    bit h[6];
`ifdef TEMP_HYST_EN
    v = '{40, 60, 60, 60, 49, 48};
    h = '{0, 0, 0, 1, 1, 0};
    n = 6;
`else
    v = '{40, 60, 60, 60, 50, 0};
    h = '{0, 0, 0, 1, 0, 0};
    n = 5;
`endif
    bus.temp_compare = 8'd50;
    rd = '{v[0], v[0], v[0], v[0]};
    bus.enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v[i]);
      wait_valid(PERIOD + 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hyst_scan%0d: got timeout, want avgValid", i); end
      checks++;
      if (bus.tooHot !== h[i]) begin
        errors++; $display("FAIL hyst_flag%0d: got %0d, want %0d", i, bus.tooHot, h[i]);
      end
      if (i < n - 1) rd = '{v[i+1], v[i+1], v[i+1], v[i+1]};
      last_avg = v[i];
    end
    bus.enable = 1'b0;
    tick(3);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    rd = '{20, 20, 20, 20};
    noack_sel = 1;
    bus.temp_compare = 8'd50;
    bus.enable = 1'b1;
    wait_req_sel(1, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_reach_sel1: got timeout, want REQ on sensor 1"); end
    n = 0;
    for (int i = 0; i < 200 && bus.sensReq; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL to_req_len: got %0d, want %0d", n, TIMEOUT); end
    checks++;
    if (bus.sensFault !== 1'b1) begin errors++; $display("FAIL to_fault_set: got %0d, want 1", bus.sensFault); end
    checks++;
    if (bus.avg !== W'(last_avg)) begin errors++; $display("FAIL to_avg_hold: got %0d, want %0d", bus.avg, last_avg); end
    noack_sel = 4;
    exp_q.push_back(20);
    wait_req_sel(0, PERIOD + 10, ok);
    checks++;
    if (!ok || bus.sensFault !== 1'b1) begin
      errors++; $display("FAIL to_fault_sticky: got %0d, want 1", bus.sensFault);
    end
    wait_valid(40, ok);
    checks++;
    if (!ok || bus.sensFault !== 1'b0 || bus.tooHot !== 1'b0) begin
      errors++; $display("FAIL to_fault_clear: got fault=%0d hot=%0d, want 0 0", bus.sensFault, bus.tooHot);
    end
    last_avg = 20;
    bus.enable = 1'b0;
    tick(3);
  endtask

  task automatic test_enable_drop();
    bit ok;
    int vld;
    rd = '{7, 7, 7, 7};
    bus.enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.sensReq && bus.busy && bus.sensSel == 2'd2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_reach_acc2: got timeout, want ACC of sensor 2"); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sensReq !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got req=%0d busy=%0d, want 0 0", bus.sensReq, bus.busy);
    end
    checks++;
    if (bus.avg !== W'(last_avg)) begin errors++; $display("FAIL drop_avg_hold: got %0d, want %0d", bus.avg, last_avg); end
    vld = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.avgValid) vld++;
      @(negedge clk);
    end
    checks++;
    if (vld != 0) begin errors++; $display("FAIL drop_no_valid: got %0d pulses, want 0", vld); end
    exp_q.push_back(7);
    bus.enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sensReq) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || bus.sensSel !== 2'd0) begin
      errors++; $display("FAIL drop_restart_sel: got req=%0d sel=%0d, want req=1 sel=0", ok, bus.sensSel);
    end
    wait_valid(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_rescan: got timeout, want avgValid"); end
    last_avg = 7;
    bus.enable = 1'b0;
    tick(3);
  endtask

  initial begin
    bus.enable       = 1'b0;
    bus.temp_compare = '0;
    rd = '{0, 0, 0, 0};
    test_reset();
    test_basic_avg();
    test_hot_debounce();
    test_hysteresis();
    test_timeout();
    test_enable_drop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
